x_23k640_slave: RTL and testbench

X_23K640_SLAVE -- requirements
Module: x_23K640_slave

---
 rtl/x_23k640_slave.sv | 239 +++++++++++++++++++++++
 tb/tb_x_23k640_slave.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/x_23k640_slave.sv
`default_nettype none
// ==========================================================================
// x_23k640_slave : 23K640-style SPI SRAM slave (mode 0), oversampled on i_clk.
// Optional status register/page/sequential modes: X_23K640_SLAVE_STATUS_EN.
// Revision: 1.0
// ==========================================================================
module x_23k640_slave #(
  parameter int ADDR_W = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sck,
  input  logic i_cs,
  input  logic i_si,
  output logic o_so
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RD   = 3'd4;
  localparam logic [2:0] S_RDSR = 3'd5;
  localparam logic [2:0] S_WRSR = 3'd6;
  localparam logic [2:0] S_DROP = 3'd7;

  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(31);

  logic              sck_s1_q, sck_s2_q, sck_prev_q;
  logic              cs_s1_q, cs_s2_q;
  logic              si_s1_q, si_s2_q;
  logic [1:0]        vld_q;
  logic              armed_q;

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        rd_sh_q, rd_sh_d;
  logic              is_rd_q, is_rd_d;
  logic              so_q, so_d;

  logic              w_rise, w_fall, w_we, w_byte_mode;
  logic [1:0]        w_mode;
  logic [7:0]        w_shift_in, w_mem_new, w_mem_inc;
  logic [ADDR_W-1:0] w_addr_in, w_addr_seq, w_addr_page, w_addr_inc;

  logic [7:0]        mem_q [0:(1<<ADDR_W)-1];

`ifdef X_23K640_SLAVE_STATUS_EN
  logic [1:0]        mode_q, mode_d;
  assign w_mode = mode_q;
`else
  assign w_mode = 2'b00;
`endif

  // armed_q blocks decode after reset until CS has truly been sampled high
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_prev_q <= 1'b0;
      cs_s1_q    <= 1'b1;
      cs_s2_q    <= 1'b1;
      si_s1_q    <= 1'b0;
      si_s2_q    <= 1'b0;
      vld_q      <= 2'b00;
      armed_q    <= 1'b0;
    end else begin
      sck_s1_q   <= i_sck;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      cs_s1_q    <= i_cs;
      cs_s2_q    <= cs_s1_q;
      si_s1_q    <= i_si;
      si_s2_q    <= si_s1_q;
      vld_q      <= {vld_q[0], 1'b1};
      armed_q    <= armed_q | (vld_q[1] & cs_s2_q);
    end
  end

  assign w_rise      = sck_s2_q & ~sck_prev_q;
  assign w_fall      = ~sck_s2_q & sck_prev_q;
  assign w_shift_in  = {shift_q[6:0], si_s2_q};
  assign w_addr_in   = {addr_q[ADDR_W-2:0], si_s2_q};
  assign w_addr_seq  = addr_q + ADDR_W'(1);
  assign w_addr_page = (addr_q & ~PAGE_MASK) | (w_addr_seq & PAGE_MASK);
  assign w_addr_inc  = (w_mode == 2'b01) ? w_addr_seq : w_addr_page;
  assign w_byte_mode = (w_mode[1] == w_mode[0]);
  assign w_mem_new   = mem_q[w_addr_in];
  assign w_mem_inc   = mem_q[w_addr_inc];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    rd_sh_d = rd_sh_q;
    is_rd_d = is_rd_q;
    so_d    = so_q;
    w_we    = 1'b0;
`ifdef X_23K640_SLAVE_STATUS_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (armed_q && !cs_s2_q) begin
          state_d = S_CMD;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      S_CMD: begin
        if (w_rise) begin
          shift_d = w_shift_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            case (w_shift_in)
              8'h03:   begin state_d = S_ADDR; is_rd_d = 1'b1; end
              8'h02:   begin state_d = S_ADDR; is_rd_d = 1'b0; end
`ifdef X_23K640_SLAVE_STATUS_EN
              8'h05:   begin state_d = S_RDSR; rd_sh_d = {w_mode, 6'b0}; end
              8'h01:   state_d = S_WRSR;
`endif
              default: state_d = S_DROP;
            endcase
          end
        end
      end
      S_ADDR: begin
        if (w_rise) begin
          addr_d = w_addr_in;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            cnt_d = '0;
            if (is_rd_q) begin
              state_d = S_RD;
              rd_sh_d = w_mem_new;
            end else begin
              state_d = S_WR;
            end
          end
        end
      end
      S_WR: begin
        if (w_rise) begin
          shift_d = w_shift_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            w_we   = 1'b1;
            cnt_d  = '0;
            addr_d = w_addr_inc;
            if (w_byte_mode) state_d = S_DROP;
          end
        end
      end
      S_RD: begin
        if (w_fall) begin
          so_d    = rd_sh_q[7];
          rd_sh_d = {rd_sh_q[6:0], 1'b0};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7 && !w_byte_mode) begin
            cnt_d   = '0;
            addr_d  = w_addr_inc;
            rd_sh_d = w_mem_inc;
          end
        end else if (w_rise && cnt_q == 4'd8) begin
          // byte mode: the master has sampled the last bit, stop driving
          state_d = S_DROP;
        end
      end
      S_RDSR: begin
        if (w_fall) begin
          so_d    = rd_sh_q[7];
          rd_sh_d = {rd_sh_q[6:0], 1'b0};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            rd_sh_d = {w_mode, 6'b0};
          end
        end
      end
      S_WRSR: begin
        if (w_rise) begin
          shift_d = w_shift_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
`ifdef X_23K640_SLAVE_STATUS_EN
            mode_d = w_shift_in[7:6];
`endif
            state_d = S_DROP;
          end
        end
      end
      default: ;
    endcase
    // CS high aborts everything, including a byte completing on this edge
    if (cs_s2_q) begin
      state_d = S_IDLE;
      w_we    = 1'b0;
    end
    if (state_d != S_RD && state_d != S_RDSR) so_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      rd_sh_q <= '0;
      is_rd_q <= 1'b0;
      so_q    <= 1'b0;
`ifdef X_23K640_SLAVE_STATUS_EN
      mode_q  <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      rd_sh_q <= rd_sh_d;
      is_rd_q <= is_rd_d;
      so_q    <= so_d;
`ifdef X_23K640_SLAVE_STATUS_EN
      mode_q  <= mode_d;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_we) mem_q[addr_q] <= w_shift_in;
  end

  assign o_so = so_q;

endmodule
`default_nettype wire

// File: tb/tb_x_23k640_slave.sv
`default_nettype none
// tb_x_23k640_slave : directed vector table plus hand-written frame sequences
// for the SPI SRAM slave; ADDR_W = 8.
module tb_x_23k640_slave;
  localparam int ADDR_W = 8;
  localparam int HALF   = 6;
  localparam int NVEC   = 14;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sck   = 1'b0;
  logic cs    = 1'b1;
  logic si    = 1'b0;
  logic so;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  x_23k640_slave #(.ADDR_W(ADDR_W)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .i_sck (sck),
    .i_cs  (cs),
    .i_si  (si),
    .o_so  (so)
  );

  typedef struct {
    bit          rd;
    logic [15:0] addr;
    logic [7:0]  data;
  } vec_t;

  vec_t tbl [NVEC];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic shift_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      si = tx[7-i];
      repeat (HALF) @(negedge clk);
      rx  = {rx[6:0], so};
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    shift_bits(tx, 8, rx);
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] r;
    cs_low();
    xfer(8'h02, r);
    xfer(a[15:8], r);
    xfer(a[7:0], r);
    xfer(d, r);
    cs_high();
  endtask

  task automatic read2(input logic [15:0] a, output logic [7:0] d0, output logic [7:0] d1);
    logic [7:0] r;
    cs_low();
    xfer(8'h03, r);
    xfer(a[15:8], r);
    xfer(a[7:0], r);
    xfer(8'h00, d0);
    xfer(8'h00, d1);
    cs_high();
  endtask

  task automatic do_read(input logic [15:0] a, output logic [7:0] d);
    logic [7:0] r;
    cs_low();
    xfer(8'h03, r);
    xfer(a[15:8], r);
    xfer(a[7:0], r);
    xfer(8'h00, d);
    cs_high();
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation still running, expected summary before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] r, r2, acc;
    // Writes first, then reads; 0x0100 aliases to 0x00, 0x13FE and 0xFFFE to 0xFE
    tbl[0]  = '{1'b0, 16'h0010, 8'hA5};
    tbl[1]  = '{1'b0, 16'h0021, 8'h5A};
    tbl[2]  = '{1'b0, 16'h0030, 8'h3C};
    tbl[3]  = '{1'b0, 16'h0040, 8'h00};
    tbl[4]  = '{1'b0, 16'h0041, 8'hFF};
    tbl[5]  = '{1'b0, 16'h0100, 8'h77};
    tbl[6]  = '{1'b0, 16'h13FE, 8'h81};
    tbl[7]  = '{1'b1, 16'h0010, 8'hA5};
    tbl[8]  = '{1'b1, 16'h0030, 8'h3C};
    tbl[9]  = '{1'b1, 16'h0041, 8'hFF};
    tbl[10] = '{1'b1, 16'h0040, 8'h00};
    tbl[11] = '{1'b1, 16'h0000, 8'h77};
    tbl[12] = '{1'b1, 16'hFFFE, 8'h81};
    tbl[13] = '{1'b1, 16'h0021, 8'h5A};

    repeat (4) @(negedge clk);
    check("reset_so", {7'b0, so}, 8'h00);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      if (tbl[i].rd) begin
        do_read(tbl[i].addr, r);
        check($sformatf("tbl%0d_rd_%04h", i, tbl[i].addr), r, tbl[i].data);
      end else begin
        do_write(tbl[i].addr, tbl[i].data);
      end
    end

    // Byte mode: second data byte of a write frame is dropped
    cs_low();
    xfer(8'h02, r); xfer(8'h00, r); xfer(8'h20, r); xfer(8'h11, r); xfer(8'h22, r);
    cs_high();
    do_read(16'h0020, r);
    check("bytemode_wr_first", r, 8'h11);
    do_read(16'h0021, r);
    check("bytemode_wr_second_ignored", r, 8'h5A);
    read2(16'h0010, r, r2);
    check("bytemode_rd_first", r, 8'hA5);
    check("bytemode_rd_second_zero", r2, 8'h00);

    // CS raised after 5 data bits; immediate new frame must decode normally
    cs_low();
    xfer(8'h02, r); xfer(8'h00, r); xfer(8'h30, r);
    shift_bits(8'hA8, 5, r);
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_so_low", {7'b0, so}, 8'h00);
    cs_low();
    xfer(8'h03, r); xfer(8'h00, r); xfer(8'h30, r); xfer(8'h00, r);
    cs_high();
    check("abort_partial_discarded", r, 8'h3C);

    // Unknown command: o_so quiet for the whole frame, no side effects
    acc = 8'h00;
    cs_low();
    xfer(8'hFF, r); acc = acc | r;
    for (int k = 0; k < 3; k++) begin
      xfer(8'h5A, r);
      acc = acc | r;
    end
    cs_high();
    check("cmd_ff_so_quiet", acc, 8'h00);
    do_read(16'h0010, r);
    check("cmd_ff_next_read", r, 8'hA5);

    // Reset mid-frame with CS held low: the following write must be ignored
    cs_low();
    xfer(8'h03, r); xfer(8'h00, r);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_so", {7'b0, so}, 8'h00);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    xfer(8'h02, r); xfer(8'h00, r); xfer(8'h10, r); xfer(8'h00, r);
    cs_high();
    do_read(16'h0010, r);
    check("midreset_no_decode", r, 8'hA5);

`ifdef X_23K640_SLAVE_STATUS_EN
    cs_low();
    xfer(8'h05, r); xfer(8'h00, r);
    cs_high();
    check("rdsr_after_reset", r, 8'h00);

    cs_low(); xfer(8'h01, r); xfer(8'h40, r); cs_high();
    cs_low();
    xfer(8'h02, r); xfer(8'h00, r); xfer(8'hFF, r); xfer(8'hEE, r); xfer(8'hEF, r);
    cs_high();
    do_read(16'h00FF, r);
    check("seq_wr_ff", r, 8'hEE);
    do_read(16'h0000, r);
    check("seq_wr_wrap_00", r, 8'hEF);
    cs_low();
    xfer(8'h05, r); xfer(8'h00, r); xfer(8'h00, r2);
    cs_high();
    check("rdsr_seq_1", r, 8'h40);
    check("rdsr_seq_repeat", r2, 8'h40);

    cs_low(); xfer(8'h01, r); xfer(8'h80, r); cs_high();
    do_write(16'h001F, 8'h5B);
    do_write(16'h003F, 8'h6C);
    read2(16'h001F, r, r2);
    check("page_rd_1f", r, 8'h5B);
    check("page_rd_wrap_00", r2, 8'hEF);
    read2(16'h003F, r, r2);
    check("page_rd_3f", r, 8'h6C);
    check("page_rd_wrap_20", r2, 8'h11);
    cs_low();
    xfer(8'h05, r); xfer(8'h00, r);
    cs_high();
    check("rdsr_page", r, 8'h80);
`else
    cs_low();
    xfer(8'h05, r); xfer(8'h00, r); xfer(8'h00, r2);
    cs_high();
    check("rdsr_disabled_so_quiet", r | r2, 8'h00);
    cs_low(); xfer(8'h01, r); xfer(8'h40, r); cs_high();
    read2(16'h00FE, r, r2);
    check("wrsr_disabled_rd_first", r, 8'h81);
    check("wrsr_disabled_still_byte", r2, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
